// File: rtl/compute_operand_forward_if.sv
// Compute-stage operand-forward bus: the forward-select enums and the
// interface that carries the R-stage operands, hazard-unit controls,
// M/W forward sources and the C-stage results.
// FORWARD_STATS_EN adds the forward statistics counter outputs.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

package HighLevelControl;

    // Encodings 4..7 are illegal and fall back to the register value.
    typedef enum logic [2:0] {
        RS1_NO_FORWARD     = 3'd0,
        RS1_COMPUTE_RESULT = 3'd1,
        RS1_RD1W           = 3'd2,
        RS1_RD1_POST_W     = 3'd3
    } rs1ForwardSrc;

    typedef enum logic [2:0] {
        RS2_NO_FORWARD     = 3'd0,
        RS2_COMPUTE_RESULT = 3'd1,
        RS2_RD1W           = 3'd2,
        RS2_RD1_POST_W     = 3'd3
    } rs2ForwardSrc;

endpackage

interface compute_operand_forward_if #(
    parameter int XLEN  = `WORD_SIZE,
    parameter int CNT_W = 32
);
    logic                           Valid_R;
    logic [XLEN-1:0]                Rs1Data_R;
    logic [XLEN-1:0]                Rs2Data_R;
    logic                           StallRC;
    HighLevelControl::rs1ForwardSrc Rs1ForwardSrc_C;
    HighLevelControl::rs2ForwardSrc Rs2ForwardSrc_C;
    logic [XLEN-1:0]                ComputeResult_M;
    logic [XLEN-1:0]                Rd1W;
    logic [XLEN-1:0]                Rs1Operand_C;
    logic [XLEN-1:0]                Rs2Operand_C;
    logic                           Valid_C;
    logic [XLEN-1:0]                Rd1PostW;
`ifdef FORWARD_STATS_EN
    logic [CNT_W-1:0]               ForwardCntCompute;
    logic [CNT_W-1:0]               ForwardCntW;
    logic [CNT_W-1:0]               ForwardCntPostW;
`endif

    // A zero-width counter is meaningless even when the counters are compiled out.
    if (CNT_W < 1) begin : g_cnt_w_check
        $error("CNT_W must be at least 1");
    end

    // Upstream side: register file, hazard unit and later pipeline stages.
    modport master (
        output Valid_R, Rs1Data_R, Rs2Data_R, StallRC,
               Rs1ForwardSrc_C, Rs2ForwardSrc_C, ComputeResult_M, Rd1W,
        input  Rs1Operand_C, Rs2Operand_C, Valid_C, Rd1PostW
`ifdef FORWARD_STATS_EN
        , input ForwardCntCompute, ForwardCntW, ForwardCntPostW
`endif
    );

    // The operand-forward block itself.
    modport slave (
        input  Valid_R, Rs1Data_R, Rs2Data_R, StallRC,
               Rs1ForwardSrc_C, Rs2ForwardSrc_C, ComputeResult_M, Rd1W,
        output Rs1Operand_C, Rs2Operand_C, Valid_C, Rd1PostW
`ifdef FORWARD_STATS_EN
        , output ForwardCntCompute, ForwardCntW, ForwardCntPostW
`endif
    );

endinterface

// File: rtl/compute_operand_forward.sv
// Compute-stage operand path: R->C operand registers, a one-cycle-delayed
// copy of the writeback result, and the rs1/rs2 forwarding muxes feeding
// the ALU and store-data path.
// FORWARD_STATS_EN adds saturating per-source forward counters.
module compute_operand_forward #(
    parameter int XLEN  = `WORD_SIZE,
    parameter int CNT_W = 32
) (
    input logic                    clk,
    input logic                    reset,
    compute_operand_forward_if.slave bus
);
    import HighLevelControl::*;

    logic [XLEN-1:0] rs1_data_d, rs1_data_q;
    logic [XLEN-1:0] rs2_data_d, rs2_data_q;
    logic            valid_d, valid_q;
    logic [XLEN-1:0] rd1_post_w_d, rd1_post_w_q;

    if (CNT_W < 1) begin : g_cnt_w_check
        $error("CNT_W must be at least 1");
    end

    // Next-state for the R->C registers (hold on stall) and the W delay line (always advances).
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        rs1_data_d   = rs1_data_q;
        rs2_data_d   = rs2_data_q;
        valid_d      = valid_q;
        rd1_post_w_d = bus.Rd1W;
        if (!bus.StallRC) begin
            rs1_data_d = bus.Rs1Data_R;
            rs2_data_d = bus.Rs2Data_R;
            valid_d    = bus.Valid_R;
        end
    end

    // Pipeline registers; reset overrides stall and capture.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (reset) begin
            rs1_data_q   <= '0;
            rs2_data_q   <= '0;
            valid_q      <= 1'b0;
            rd1_post_w_q <= '0;
        end else begin
            rs1_data_q   <= rs1_data_d;
            rs2_data_q   <= rs2_data_d;
            valid_q      <= valid_d;
            rd1_post_w_q <= rd1_post_w_d;
        end
    end

    // Operand muxes; illegal selects fall back to the register value.
    always_comb begin
        case (bus.Rs1ForwardSrc_C)
            RS1_COMPUTE_RESULT: bus.Rs1Operand_C = bus.ComputeResult_M;
            RS1_RD1W:           bus.Rs1Operand_C = bus.Rd1W;
            RS1_RD1_POST_W:     bus.Rs1Operand_C = rd1_post_w_q;
            default:            bus.Rs1Operand_C = rs1_data_q;
        endcase
        case (bus.Rs2ForwardSrc_C)
            RS2_COMPUTE_RESULT: bus.Rs2Operand_C = bus.ComputeResult_M;
            RS2_RD1W:           bus.Rs2Operand_C = bus.Rd1W;
            RS2_RD1_POST_W:     bus.Rs2Operand_C = rd1_post_w_q;
            default:            bus.Rs2Operand_C = rs2_data_q;
        endcase
    end

    assign bus.Valid_C  = valid_q;
    assign bus.Rd1PostW = rd1_post_w_q;

`ifdef FORWARD_STATS_EN
    logic [CNT_W-1:0] fwd_cnt_compute_d, fwd_cnt_compute_q;
    logic [CNT_W-1:0] fwd_cnt_w_d,       fwd_cnt_w_q;
    logic [CNT_W-1:0] fwd_cnt_post_w_d,  fwd_cnt_post_w_q;
    logic             count_en;
    logic             use_compute, use_w, use_post_w;

    // Count one per counting cycle per source, saturating at all-ones.
    always_comb begin
        count_en    = valid_q && !bus.StallRC;
        use_compute = (bus.Rs1ForwardSrc_C == RS1_COMPUTE_RESULT) ||
                      (bus.Rs2ForwardSrc_C == RS2_COMPUTE_RESULT);
        use_w       = (bus.Rs1ForwardSrc_C == RS1_RD1W) ||
                      (bus.Rs2ForwardSrc_C == RS2_RD1W);
        use_post_w  = (bus.Rs1ForwardSrc_C == RS1_RD1_POST_W) ||
                      (bus.Rs2ForwardSrc_C == RS2_RD1_POST_W);
        fwd_cnt_compute_d = fwd_cnt_compute_q;
        fwd_cnt_w_d       = fwd_cnt_w_q;
        fwd_cnt_post_w_d  = fwd_cnt_post_w_q;
        if (count_en && use_compute && (fwd_cnt_compute_q != '1))
            fwd_cnt_compute_d = fwd_cnt_compute_q + 1'b1;
        if (count_en && use_w && (fwd_cnt_w_q != '1))
            fwd_cnt_w_d = fwd_cnt_w_q + 1'b1;
        if (count_en && use_post_w && (fwd_cnt_post_w_q != '1))
            fwd_cnt_post_w_d = fwd_cnt_post_w_q + 1'b1;
    end

    // Statistics counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            fwd_cnt_compute_q <= '0;
            fwd_cnt_w_q       <= '0;
            fwd_cnt_post_w_q  <= '0;
        end else begin
            fwd_cnt_compute_q <= fwd_cnt_compute_d;
            fwd_cnt_w_q       <= fwd_cnt_w_d;
            fwd_cnt_post_w_q  <= fwd_cnt_post_w_d;
        end
    end

    assign bus.ForwardCntCompute = fwd_cnt_compute_q;
    assign bus.ForwardCntW       = fwd_cnt_w_q;
    assign bus.ForwardCntPostW   = fwd_cnt_post_w_q;
`endif

`ifndef SYNTHESIS
    // Flag select encodings that have no defined source.
    always @(posedge clk) begin
        if (!reset) begin
            assert ($isunknown(bus.Rs1ForwardSrc_C) || bus.Rs1ForwardSrc_C inside
                    {RS1_NO_FORWARD, RS1_COMPUTE_RESULT, RS1_RD1W, RS1_RD1_POST_W})
                else $error("illegal Rs1ForwardSrc_C 0x%0h", bus.Rs1ForwardSrc_C);
            assert ($isunknown(bus.Rs2ForwardSrc_C) || bus.Rs2ForwardSrc_C inside
                    {RS2_NO_FORWARD, RS2_COMPUTE_RESULT, RS2_RD1W, RS2_RD1_POST_W})
                else $error("illegal Rs2ForwardSrc_C 0x%0h", bus.Rs2ForwardSrc_C);
        end
    end
`endif

endmodule

// File: tb/tb_compute_operand_forward.sv
// Directed testbench for compute_operand_forward: reset, capture, each
// forward source, load stall, stall+valid drop, reset during stall and,
// with FORWARD_STATS_EN, the statistics counters.
module tb_compute_operand_forward;
    import HighLevelControl::*;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    compute_operand_forward_if #(.XLEN(32), .CNT_W(32)) bus ();

    compute_operand_forward #(.XLEN(32), .CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // 10-unit clock period.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge, then settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset                = 1'b1;
        bus.Valid_R          = 1'b0;
        bus.Rs1Data_R        = '0;
        bus.Rs2Data_R        = '0;
        bus.StallRC          = 1'b0;
        bus.Rs1ForwardSrc_C  = RS1_NO_FORWARD;
        bus.Rs2ForwardSrc_C  = RS2_NO_FORWARD;
        bus.ComputeResult_M  = '0;
        bus.Rd1W             = 32'h123;

        // Reset for two cycles: everything cleared even though Rd1W is nonzero.
        tick();
        tick();
        check("reset_rs1", bus.Rs1Operand_C, 0);
        check("reset_rs2", bus.Rs2Operand_C, 0);
        check("reset_valid", bus.Valid_C, 0);
        check("reset_postw", bus.Rd1PostW, 0);

        // First capture.
        reset         = 1'b0;
        bus.Rs1Data_R = 32'h11;
        bus.Rs2Data_R = 32'h22;
        bus.Valid_R   = 1'b1;
        tick();
        check("cap_rs1", bus.Rs1Operand_C, 32'h11);
        check("cap_rs2", bus.Rs2Operand_C, 32'h22);
        check("cap_valid", bus.Valid_C, 1);
        check("cap_postw", bus.Rd1PostW, 32'h123);

        // Compute-result forward on rs1, combinational.
        bus.Rs1ForwardSrc_C = RS1_COMPUTE_RESULT;
        bus.ComputeResult_M = 32'hA;
        #1;
        check("fwd_compute_rs1", bus.Rs1Operand_C, 32'hA);
        check("fwd_compute_rs2_unaff", bus.Rs2Operand_C, 32'h22);

        // Rd1W forward on rs2.
        bus.Rs2ForwardSrc_C = RS2_RD1W;
        bus.Rd1W            = 32'h55;
        #1;
        check("fwd_w_rs2", bus.Rs2Operand_C, 32'h55);

        // Load stall: C holds 0x33/0x5, new R data 0x99 offered during the stall.
        bus.Rs1ForwardSrc_C = RS1_NO_FORWARD;
        bus.Rs2ForwardSrc_C = RS2_NO_FORWARD;
        bus.Rs1Data_R       = 32'h33;
        bus.Rs2Data_R       = 32'h5;
        tick();
        check("pre_stall_rs2", bus.Rs2Operand_C, 32'h5);
        bus.StallRC         = 1'b1;
        bus.Rs2ForwardSrc_C = RS2_RD1W;
        bus.Rs1Data_R       = 32'h99;
        bus.Rs2Data_R       = 32'h99;
        bus.Rd1W            = 32'h1111;
        tick();
        bus.StallRC = 1'b0;
        bus.Rd1W    = 32'hDEAD;
        #1;
        check("stall_rs2_w", bus.Rs2Operand_C, 32'hDEAD);
        check("stall_rs1_hold", bus.Rs1Operand_C, 32'h33);
        check("stall_postw_adv", bus.Rd1PostW, 32'h1111);
        bus.Rs2ForwardSrc_C = RS2_NO_FORWARD;
        #1;
        check("stall_rs2_hold", bus.Rs2Operand_C, 32'h5);

        // Stall with Valid_R=1 while C is invalid: the valid is not captured.
        bus.Valid_R = 1'b0;
        tick();
        check("invalid_cap", bus.Valid_C, 0);
        check("invalid_operand_driven", bus.Rs1Operand_C, 32'h99);
        bus.StallRC = 1'b1;
        bus.Valid_R = 1'b1;
        tick();
        check("stall_drop_valid", bus.Valid_C, 0);

        // PostW forward: Rd1W=0x64 in cycle n, selected via PostW in n+1.
        bus.StallRC = 1'b0;
        bus.Rd1W    = 32'h64;
        tick();
        bus.Rd1W            = 32'h77;
        bus.Rs1ForwardSrc_C = RS1_RD1_POST_W;
        bus.Rs2ForwardSrc_C = RS2_RD1_POST_W;
        #1;
        check("fwd_postw_rs1", bus.Rs1Operand_C, 32'h64);
        check("fwd_postw_rs2", bus.Rs2Operand_C, 32'h64);

        // Reset asserted during a stall.
        bus.Rs1ForwardSrc_C = RS1_NO_FORWARD;
        bus.Rs2ForwardSrc_C = RS2_NO_FORWARD;
        bus.Rs1Data_R       = 32'h44;
        bus.Rs2Data_R       = 32'h45;
        bus.Valid_R         = 1'b1;
        tick();
        check("pre_rst_valid", bus.Valid_C, 1);
        bus.StallRC = 1'b1;
        reset       = 1'b1;
        tick();
        check("rst_stall_valid", bus.Valid_C, 0);
        check("rst_stall_postw", bus.Rd1PostW, 0);
        check("rst_stall_rs1", bus.Rs1Operand_C, 0);
        reset         = 1'b0;
        bus.StallRC   = 1'b0;
        bus.Rs1Data_R = 32'h66;
        tick();
        check("post_rst_rs1", bus.Rs1Operand_C, 32'h66);
        check("post_rst_valid", bus.Valid_C, 1);

`ifdef FORWARD_STATS_EN
        // Counters start from the reset above; Valid_C stays 1 throughout.
        check("cnt_reset", bus.ForwardCntCompute, 0);
        bus.Rs1ForwardSrc_C = RS1_COMPUTE_RESULT;
        tick();
        bus.Rs2ForwardSrc_C = RS2_COMPUTE_RESULT;
        tick();
        bus.Rs2ForwardSrc_C = RS2_NO_FORWARD;
        bus.StallRC         = 1'b1;
        tick();
        bus.StallRC = 1'b0;
        tick();
        check("cnt_compute", bus.ForwardCntCompute, 3);
        check("cnt_w", bus.ForwardCntW, 0);
        check("cnt_postw", bus.ForwardCntPostW, 0);

        // Saturation at all-ones.
        force dut.fwd_cnt_compute_q = '1;
        #1;
        release dut.fwd_cnt_compute_q;
        tick();
        check("cnt_saturate", bus.ForwardCntCompute, 32'hFFFF_FFFF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/compute_operand_forward.md
Name: compute_operand_forward

Overview:
- Compute-stage (C) operand path, directly downstream of the hazzard unit; consumes its registered forward selects and StallRC.
- Holds the R->C operand pipeline registers and keeps a one-cycle-delayed copy of the writeback result (Rd1PostW).
- Muxes the final rs1/rs2 operands fed to the ALU and the store-data path.

Parameters:
- XLEN, default `WORD_SIZE (32): operand/result width.
- CNT_W, default 32: width of the forward statistics counters (only used under FORWARD_STATS_EN).

Ports:
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high
- Valid_R  in  1  R-stage instruction valid
- Rs1Data_R  in  XLEN  register-file rs1 read data
- Rs2Data_R  in  XLEN  register-file rs2 read data
- StallRC  in  1  hold R->C registers (from hazzard unit)
- Rs1ForwardSrc_C  in  HighLevelControl::rs1ForwardSrc  rs1 select (registered in hazzard unit)
- Rs2ForwardSrc_C  in  HighLevelControl::rs2ForwardSrc  rs2 select
- ComputeResult_M  in  XLEN  result of instruction one ahead (now in M)
- Rd1W  in  XLEN  final writeback data (load data or truncated result)
- Rs1Operand_C  out  XLEN  forwarded rs1 operand
- Rs2Operand_C  out  XLEN  forwarded rs2 operand / store data
- Valid_C  out  1  C-stage instruction valid
- Rd1PostW  out  XLEN  Rd1W delayed one cycle (observability)

Behaviour:
- Registers: Rs1Data_C, Rs2Data_C, Valid_C, Rd1PostW_q. On reset, all are cleared to 0 and reset wins over every other input.
- R->C capture: when StallRC=0, Rs1Data_R, Rs2Data_R and Valid_R are captured on posedge. When StallRC=1, all three hold their value.
- Rd1PostW_q <= Rd1W on every cycle, regardless of StallRC. It must advance during a load stall so the value of a retired older instruction is still available.
- Operand mux (combinational, zero latency from the select):
  - NO_FORWARD -> Rs1Data_C
  - ComputeResult -> ComputeResult_M
  - Rd1W -> Rd1W
  - Rd1PostW -> Rd1PostW_q
  - rs2 path is identical with its own select.
- Any unlisted or illegal select value -> Rs1Data_C/Rs2Data_C (safe default). A simulation-only assertion fires on it.
- Valid_C=0 does not gate the operands. The mux still drives them; downstream ignores them.
- Load-stall sequence: the hazzard unit asserts StallRC for one cycle and holds its select.
  - The C-stage operand values may change during the stall cycle.
  - Only the value presented in the cycle after StallRC deasserts is architecturally used.
- Simultaneous StallRC=1 and Valid_R=1: Valid_R is dropped here. The hazzard unit also stalls IR, so the instruction is re-presented.
- Reset asserted mid-stall: all registers are cleared. The next non-reset cycle captures the R stage normally.
- No internal state machine beyond the registers. All outputs are combinational from the registers and the M/W inputs.

Optional Feature:
- Macro: FORWARD_STATS_EN.
- When defined, adds outputs ForwardCntCompute, ForwardCntW, ForwardCntPostW (CNT_W each).
  - Each counts cycles in which Valid_C=1, StallRC=0 and either rs1 or rs2 uses that source.
  - Both operands using the same source in the same cycle add 1, not 2.
  - Counters reset to 0, saturate at all-ones (no wrap) and hold during StallRC=1.
- When undefined, the ports and logic are absent and the behaviour is otherwise identical.

Test Plan:
- Reset, then capture: hold reset 2 cycles -> all outputs 0. Then Rs1Data_R=0x11, Rs2Data_R=0x22, Valid_R=1, selects NO_FORWARD -> next cycle Rs1Operand_C=0x11, Rs2Operand_C=0x22, Valid_C=1.
- Compute forward: Rs1ForwardSrc_C=ComputeResult, ComputeResult_M=0xA -> Rs1Operand_C=0xA in the same cycle; Rs2Operand_C unaffected.
- Load stall: C holds Rs2Data=0x5. StallRC=1 for 1 cycle with Rs2 select Rd1W; Rd1W=0xDEAD after the stall; new R data 0x99 presented during the stall -> Rs2Operand_C=0xDEAD, Rs1Data_C keeps its pre-stall value, 0x99 not captured.
- PostW forward: Rd1W=0x64 in cycle n, then Rs1 select Rd1PostW in cycle n+1 with Rd1W=0x77 -> Rs1Operand_C=0x64.
- Reset mid-stall: StallRC=1 with reset=1 -> next cycle Valid_C=0 and Rd1PostW=0; the cycle after, normal capture resumes.
- FORWARD_STATS_EN: 3 valid cycles with rs1=ComputeResult, rs2=ComputeResult in one of them, plus 1 stalled cycle -> ForwardCntCompute=3. Preloading a counter to all-ones (force) -> it stays all-ones.
